ray_dispatcher: RTL and testbench



---
 rtl/ray_dispatcher.sv | 169 ++++++++++++++++
 tb/tb_ray_dispatcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: primary-ray source for the ray tracer core.
//
// Raster-scans an H_RES x V_RES frame. For every pixel it drives the latched camera origin and a
// per-pixel direction onto the tracer, holds the ray for HOLD_CYCLES, then writes the tracer
// colour to VRAM with a single-cycle strobe. One pixel every HOLD_CYCLES+2 cycles.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   start       single-cycle frame start request (ignored while busy or in the done cycle)
//   cam_pos     camera origin {z[8:0], y[8:0], x[9:0]}, latched at frame start
//   pix_color   12-bit tracer colour, sampled in the write cycle
//   init        ray origin to tracer
//   dir         ray direction {dz[9:0], dy[9:0], dx[10:0]}, two's complement
//   vram_addr   pixel write address (running counter, equals y*H_RES+x)
//   vram_data   pixel colour (pix_color during the write cycle, 0 otherwise)
//   vram_we     write strobe, one cycle per pixel
//   busy        high from frame start until frame completion
//   frame_done  one-cycle pulse after the last pixel write
//
// Optional feature: define RAY_DISPATCH_LOOP_EN to render frames back to back. The done cycle
// still pulses frame_done, then re-latches cam_pos and restarts at pixel (0,0) with busy held high.

module ray_dispatcher #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned FOCAL       = 256,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned ADDR_W      = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [27:0]       cam_pos,
    input  logic [11:0]       pix_color,
    output logic [27:0]       init,
    output logic [30:0]       dir,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [11:0]       vram_data,
    output logic              vram_we,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWrite,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [27:0]       init_q, init_d;
    logic [30:0]       dir_q, dir_d;

    logic [10:0] dx;
    logic [9:0]  dy;
    logic        last_x;
    logic        last_y;

    // Centre the screen on the optical axis: +dy points up, so row 0 is the top.
    assign dx     = {1'b0, x_q} - 11'(H_RES / 2);
    assign dy     = 10'(V_RES / 2 - 1) - {1'b0, y_q};
    assign last_x = (x_q == 10'(H_RES - 1));
    assign last_y = (y_q == 9'(V_RES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            init_q  <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            init_q  <= init_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        init_d     = init_q;
        dir_d      = dir_q;
        vram_we    = 1'b0;
        vram_data  = '0;
        busy       = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    init_d  = cam_pos;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                busy    = 1'b1;
                dir_d   = {10'(FOCAL), dy, dx};
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                busy  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                busy      = 1'b1;
                vram_we   = 1'b1;
                vram_data = pix_color;
                addr_d    = addr_q + ADDR_W'(1);
                if (last_x && last_y) begin
                    state_d = StDone;
                end else if (last_x) begin
                    x_d     = '0;
                    y_d     = y_q + 9'd1;
                    state_d = StIssue;
                end else begin
                    x_d     = x_q + 10'd1;
                    state_d = StIssue;
                end
            end
            StDone: begin
                frame_done = 1'b1;
`ifdef RAY_DISPATCH_LOOP_EN
                busy    = 1'b1;
                init_d  = cam_pos;
                x_d     = '0;
                y_d     = '0;
                addr_d  = '0;
                state_d = StIssue;
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign init      = init_q;
    assign dir       = dir_q;
    assign vram_addr = addr_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher on a 4x2 frame, HOLD_CYCLES=4, FOCAL=256.
// A cycle-level reference model derives every expected output from the cycle count since the
// frame start (pixel = count / period, phase = count % period). A vector table pins down the
// first frame's per-pixel addresses, directions and colours; hand sequences cover the late colour
// change, camera latching, ignored starts and a mid-frame reset; a random phase follows.

module tb_ray_dispatcher;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int HOLD = 4;
    localparam int FOC  = 256;
    localparam int NPIX = H * V;
    localparam int PER  = HOLD + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [27:0] cam_pos;
    logic [11:0] pix_color;
    logic [27:0] init;
    logic [30:0] dir;
    logic [18:0] vram_addr;
    logic [11:0] vram_data;
    logic        vram_we;
    logic        busy;
    logic        frame_done;

    ray_dispatcher #(
        .H_RES      (H),
        .V_RES      (V),
        .FOCAL      (FOC),
        .HOLD_CYCLES(HOLD),
        .ADDR_W     (19)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cam_pos   (cam_pos),
        .pix_color (pix_color),
        .init      (init),
        .dir       (dir),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_we   (vram_we),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: k = cycles since the start cycle (0 = no frame in flight).
    int          k           = 0;
    logic [27:0] m_init      = '0;
    logic [30:0] m_dir       = '0;
    int          m_idle_addr = 0;

    typedef struct {
        logic [11:0] pix;
        logic [10:0] dx;
        logic [9:0]  dy;
        logic [18:0] addr;
    } vec_t;
    vec_t tbl[NPIX];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [30:0] dir_of(int p);
        logic [31:0] dxv, dyv, dzv;
        dxv = 32'(p % H - H / 2);
        dyv = 32'(V / 2 - 1 - p / H);
        dzv = 32'(FOC);
        return {dzv[9:0], dyv[9:0], dxv[10:0]};
    endfunction

    task automatic model_check();
        int          p, ph;
        logic        we_e, busy_e, fd_e;
        logic [31:0] addr_e;
        logic [30:0] dir_e;
        if (!rst) begin
            k = 0; m_init = '0; m_dir = '0; m_idle_addr = 0;
        end
        if (k == 0) begin
            we_e = 0; busy_e = 0; fd_e = 0; addr_e = 32'(m_idle_addr); dir_e = m_dir;
        end else if (k <= NPIX * PER) begin
            p = (k - 1) / PER;
            ph = (k - 1) % PER;
            we_e = (ph == PER - 1); busy_e = 1; fd_e = 0; addr_e = 32'(p);
            dir_e = (ph == 0) ? m_dir : dir_of(p);
        end else begin
            we_e = 0; busy_e = 0; fd_e = 1; addr_e = 32'(NPIX); dir_e = dir_of(NPIX - 1);
        end
        chk("vram_we", 32'(vram_we), 32'(we_e));
        chk("busy", 32'(busy), 32'(busy_e));
        chk("frame_done", 32'(frame_done), 32'(fd_e));
        chk("vram_addr", 32'(vram_addr), addr_e);
        chk("dir", 32'(dir), 32'(dir_e));
        chk("init", 32'(init), 32'(m_init));
        if (we_e) chk("vram_data", 32'(vram_data), 32'(pix_color));
        if (!rst) chk("vram_data_rst", 32'(vram_data), 32'h0);
    endtask

    // Advance the model by the posedge that is about to sample the current inputs.
    task automatic model_advance();
        if (!rst) begin
            k = 0; m_init = '0; m_dir = '0; m_idle_addr = 0;
        end else if (k == 0) begin
            if (start) begin
                k = 1;
                m_init = cam_pos;
            end
        end else if (k == NPIX * PER + 1) begin
            k = 0;
            m_idle_addr = NPIX;
        end else begin
            if ((k - 1) % PER == 0) m_dir = dir_of((k - 1) / PER);
            k++;
        end
    endtask

    task automatic cycle();
        model_advance();
        @(negedge clk);
        model_check();
    endtask

    task automatic goto_k(int target);
        for (int i = 0; i < 200 && k != target; i++) cycle();
        if (k != target) begin
            n_checks++;
            n_errors++;
            $display("FAIL goto_k: model at %0d, wanted %0d", k, target);
        end
    endtask

    initial begin
        for (int p = 0; p < NPIX; p++) begin
            tbl[p].pix  = 12'(12'h1A0 + 12'(p * 37));
            tbl[p].addr = 19'(p);
        end
        tbl[0].dx = 11'h7FE; tbl[0].dy = 10'h000;
        tbl[1].dx = 11'h7FF; tbl[1].dy = 10'h000;
        tbl[2].dx = 11'h000; tbl[2].dy = 10'h000;
        tbl[3].dx = 11'h001; tbl[3].dy = 10'h000;
        tbl[4].dx = 11'h7FE; tbl[4].dy = 10'h3FF;
        tbl[5].dx = 11'h7FF; tbl[5].dy = 10'h3FF;
        tbl[6].dx = 11'h000; tbl[6].dy = 10'h3FF;
        tbl[7].dx = 11'h001; tbl[7].dy = 10'h3FF;

        rst = 1'b0; start = 1'b0; cam_pos = '0; pix_color = '0;
        @(negedge clk);
        model_check();
        cycle();
        rst = 1'b1;
        cycle();

        // Frame 1, table driven; a start pulse at the 3rd write must be ignored.
        cam_pos = 28'hABCDEF1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int p = 0; p < NPIX; p++) begin
            pix_color = tbl[p].pix;
            repeat (PER - 1) cycle();
            chk("tbl_we", 32'(vram_we), 32'h1);
            chk("tbl_addr", 32'(vram_addr), 32'(tbl[p].addr));
            chk("tbl_dir", 32'(dir), 32'({10'd256, tbl[p].dy, tbl[p].dx}));
            chk("tbl_data", 32'(vram_data), 32'(tbl[p].pix));
            if (p == 2) start = 1'b1;
            cycle();
            start = 1'b0;
        end
        chk("done_pulse", 32'(frame_done), 32'h1);
        chk("done_busy", 32'(busy), 32'h0);
        start = 1'b1;   // start during the done cycle is ignored
        cycle();
        start = 1'b0;
        chk("idle_after_done", 32'(busy), 32'h0);
        repeat (3) cycle();

        // Colour sampled in the write cycle; camera latched only at start.
        cam_pos = 28'h1234567;
        start = 1'b1;
        cycle();
        start = 1'b0;
        pix_color = 12'hFFF;
        repeat (PER - 2) cycle();
        pix_color = 12'h000;
        cam_pos = '0;
        cycle();
        chk("late_color", 32'(vram_data), 32'h0);
        chk("init_hold", 32'(init), 32'h1234567);
        goto_k(NPIX * PER + 1);
        chk("init_at_done", 32'(init), 32'h1234567);
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("init_relatch", 32'(init), 32'h0);

        // Reset during the hold of pixel 5.
        goto_k(5 * PER + 3);
        rst = 1'b0;
        #1;
        model_check();
        chk("rst_addr", 32'(vram_addr), 32'h0);
        cycle();
        rst = 1'b1;
        repeat (10) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        goto_k(PER);
        chk("restart_we", 32'(vram_we), 32'h1);
        chk("restart_addr0", 32'(vram_addr), 32'h0);
        goto_k(0);

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            pix_color = 12'($urandom);
            if ($urandom_range(0, 9) == 0) cam_pos = 28'($urandom);
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #1;
                model_check();
            end else begin
                rst = 1'b1;
            end
            cycle();
        end
        rst = 1'b1;
        start = 1'b0;
        cycle();
        goto_k(0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
